clip_obj_fetch: RTL and testbench
=================================

Name: clip_obj_fetch

Overview:
Read-side sequencer for the video memory object RAM's clip port. On a start pulse it walks a contiguous range of 144-bit object words via clip_addr/clip_rd_en, absorbs the RAM's one-cycle read latency, unpacks each word into vertex/colour/type fields, and presents them to the clipping stage over a valid/ready handshake with full-rate throughput and backpressure.

Parameters:
ADDR_W, 9, object RAM address width; addresses wrap modulo 2^ADDR_W.
OBJ_W, 144, object word width; field map fixed as below.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a fetch run (sampled in IDLE only)
abort  in  1  synchronous flush back to IDLE
base_addr  in  ADDR_W  first object address, sampled with start
obj_count  in  ADDR_W  number of objects to fetch, sampled with start
clip_addr  out  ADDR_W  RAM clip-port read address
clip_rd_en  out  1  RAM clip-port read enable
clip_obj_in  in  OBJ_W  RAM clip-port data, valid the cycle after clip_rd_en
obj_valid  out  1  unpacked object available
obj_ready  in  1  downstream accepts object
x0,y0,x1,y1,x2,y2,x3,y3  out  16 each  vertex fields
color  out  12  object colour
obj_type  out  4  object type
obj_idx  out  ADDR_W  index (0-based) of presented object within run
busy  out  1  high in FETCH
done  out  1  one-cycle pulse on run completion

Behaviour:
- Field map: x0[15:0], y0[31:16], x1[47:32], y1[63:48], x2[79:64], y2[95:80], x3[111:96], y3[127:112], color[139:128], obj_type[143:140].
- Reset (async): state IDLE; issue/pop counters, inflight flag, FIFO pointers cleared; obj_valid, busy, done, clip_rd_en = 0; clip_addr, all field outputs, obj_idx = 0.
- States: IDLE, FETCH. IDLE + start -> latch base/count; count==0 -> done pulse next cycle, stay IDLE; else -> FETCH. start in FETCH ignored.
- Storage: 2-entry FIFO of unpacked objects plus obj index; outputs driven from FIFO head registers (no combinational path clip_obj_in -> outputs).
- pop = obj_valid & obj_ready. obj_valid = FIFO non-empty.
- Issue (combinational): clip_rd_en = FETCH & issued<count & (occupancy + inflight - pop) < 2. clip_addr = base + issued, wrapping modulo 2^ADDR_W; clip_addr held at last value when not issuing.
- inflight <= clip_rd_en each cycle; when inflight, clip_obj_in is pushed into FIFO at the next edge.
- Latency: start high in cycle 0 -> clip_rd_en cycle 1 -> data cycle 2 -> obj_valid cycle 3. With obj_ready held high, one object per cycle sustained.
- Backpressure: obj_valid/fields stable while obj_ready low; never more than 2 objects held + in flight, no overflow, no dropped data.
- Completion: when popped count reaches obj_count (pop on last object), state -> IDLE, done high exactly the following cycle, busy low.
- abort (FETCH or IDLE): next edge FIFO emptied, inflight data discarded, obj_valid 0, state IDLE, no done pulse. abort wins over start in same cycle.
- Reset mid-run: immediate clear, no done, clip_rd_en low asynchronously.

Test Plan:
- Preload addr 4..7 with distinct words; start base=4 count=4, obj_ready=1 -> clip_rd_en cycles 1-4 addrs 4,5,6,7; obj_valid cycles 3-6 with matching fields, obj_idx 0..3; done in cycle 7 only.
- Same run with obj_ready toggled 1,0,0,1,... -> no reads beyond occupancy limit, every object delivered once, in order, fields stable while stalled.
- base=510 count=4 -> clip_addr sequence 510,511,0,1; data matches.
- count=0 -> no clip_rd_en, done one cycle after start, obj_valid never high.
- abort asserted with 1 object buffered and 1 in flight -> obj_valid 0 next cycle, no done; new start base=0 count=1 delivers word 0 only.
- Word with bits[143:128]=16'hA5C3 -> obj_type=4'hA, color=12'h5C3; rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/clip_obj_fetch.sv
// Clip-port read sequencer for the object RAM: walks an address range, absorbs the
// one-cycle RAM latency and presents unpacked objects over a valid/ready handshake.
module clip_obj_fetch #(
  parameter int ADDR_W = 9,
  parameter int OBJ_W  = 144
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] obj_count,
  output logic [ADDR_W-1:0] clip_addr,
  output logic              clip_rd_en,
  input  logic [OBJ_W-1:0]  clip_obj_in,
  output logic              obj_valid,
  input  logic              obj_ready,
  output logic [15:0]       x0,
  output logic [15:0]       y0,
  output logic [15:0]       x1,
  output logic [15:0]       y1,
  output logic [15:0]       x2,
  output logic [15:0]       y2,
  output logic [15:0]       x3,
  output logic [15:0]       y3,
  output logic [11:0]       color,
  output logic [3:0]        obj_type,
  output logic [ADDR_W-1:0] obj_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] popped_q, popped_d;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic [OBJ_W-1:0]  mem_q [2];
  logic [ADDR_W-1:0] idx_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              pop, push;
  logic [2:0]        committed;
  logic [ADDR_W-1:0] push_idx;
  logic [OBJ_W-1:0]  head;

  assign obj_valid = (occ_q != 2'd0);
  assign pop       = obj_valid & obj_ready;
  assign push      = inflight_q & ~abort;
  // Objects already buffered or in flight after this cycle's pop; caps issue so the
  // two-entry buffer can never overflow.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign push_idx  = popped_q + ADDR_W'(occ_q);

  assign clip_rd_en = (state_q == FETCH) && (issued_q < count_q) && (committed < 3'd2);
  assign clip_addr  = clip_rd_en ? (base_q + issued_q) : addr_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    inflight_d = clip_rd_en;
    done_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    if (abort) begin
      state_d    = IDLE;
      inflight_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      occ_d      = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_d   = base_addr;
            count_d  = obj_count;
            issued_d = '0;
            popped_d = '0;
            if (obj_count == '0) done_d = 1'b1;
            else                 state_d = FETCH;
          end
        end
        FETCH: begin
          if (clip_rd_en) issued_d = issued_q + ADDR_W'(1);
          if (pop) begin
            popped_d = popped_q + ADDR_W'(1);
            if (popped_q + ADDR_W'(1) == count_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      addr_q     <= clip_addr;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Buffer storage is reset too so every field output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= clip_obj_in;
      idx_q[wr_ptr_q] <= push_idx;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign x0       = head[15:0];
  assign y0       = head[31:16];
  assign x1       = head[47:32];
  assign y1       = head[63:48];
  assign x2       = head[79:64];
  assign y2       = head[95:80];
  assign x3       = head[111:96];
  assign y3       = head[127:112];
  assign color    = head[139:128];
  assign obj_type = head[143:140];
  assign obj_idx  = idx_q[rd_ptr_q];
  assign busy     = (state_q == FETCH);
  assign done     = done_q;

endmodule

// File: tb/tb_clip_obj_fetch.sv
// Bench for clip_obj_fetch: object RAM model, per-run scoreboard, directed corner cases.
module tb_clip_obj_fetch;
  localparam int AW    = 9;
  localparam int OW    = 144;
  localparam int DEPTH = 512;

  logic          clk, rst_n, start, abort, obj_ready;
  logic [AW-1:0] base_addr, obj_count, clip_addr, obj_idx;
  logic          clip_rd_en, obj_valid, busy, done;
  logic [OW-1:0] clip_obj_in;
  logic [15:0]   x0, y0, x1, y1, x2, y2, x3, y3;
  logic [11:0]   color;
  logic [3:0]    obj_type;

  logic [OW-1:0] ram [DEPTH];
  int checks = 0;
  int errors = 0;

  clip_obj_fetch #(.ADDR_W(AW), .OBJ_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .obj_count(obj_count),
    .clip_addr(clip_addr), .clip_rd_en(clip_rd_en), .clip_obj_in(clip_obj_in),
    .obj_valid(obj_valid), .obj_ready(obj_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .color(color), .obj_type(obj_type), .obj_idx(obj_idx),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the read enable.
  always @(posedge clk) if (clip_rd_en) clip_obj_in <= ram[clip_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] out_word();
    return {obj_type, color, y3, x3, y2, x2, y1, x1, y0, x0};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, obj_valid, 1'b0);
    chk({tag, " rd_en"}, clip_rd_en, 1'b0);
    chk({tag, " addr"},  clip_addr, 0);
    chk({tag, " busy"},  busy, 1'b0);
    chk({tag, " done"},  done, 1'b0);
    chk({tag, " fields"}, out_word(), 0);
    chk({tag, " idx"},   obj_idx, 0);
  endtask

  // One fetch run: cycle 0 is the cycle start is high. Expected order, addresses,
  // indices, completion timing and the two-object limit all come from the run's
  // parameters and the RAM array.
  task automatic run(input int base, input int cnt, input int mode,
                     input int e_rd, input int e_val, input int e_done, input string tag);
    int reads = 0, pops = 0, last_pop = -1;
    int first_rd = -1, first_val = -1, done_seen = -1;
    bit stalled = 0, rdy, exp_done, exp_busy;
    logic [OW-1:0] held = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start     = (c == 0);
      base_addr = AW'(base);
      obj_count = AW'(cnt);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (c % 4 == 0) || (c % 4 == 3);
      else                rdy = ($urandom_range(0, 1) == 1);
      obj_ready = rdy;
      #1;
      if (clip_rd_en) begin
        if (first_rd < 0) first_rd = c;
        chk($sformatf("%s read_allowed c%0d", tag, c), reads < cnt, 1'b1);
        chk($sformatf("%s addr c%0d", tag, c), clip_addr, (base + reads) % DEPTH);
        reads++;
      end
      if (obj_valid) begin
        if (first_val < 0) first_val = c;
        if (stalled) chk($sformatf("%s stable c%0d", tag, c), out_word(), held);
        if (rdy) begin
          chk($sformatf("%s extra_obj c%0d", tag, c), pops < cnt, 1'b1);
          chk($sformatf("%s idx c%0d", tag, c), obj_idx, pops);
          chk($sformatf("%s word c%0d", tag, c), out_word(), ram[(base + pops) % DEPTH]);
          pops++;
          if (pops == cnt) last_pop = c;
        end
        stalled = !rdy;
        held    = out_word();
      end else begin
        stalled = 0;
      end
      chk($sformatf("%s limit c%0d", tag, c), (reads - pops) <= 2, 1'b1);
      exp_done = (cnt == 0) ? (c == 1) : (last_pop >= 0 && c == last_pop + 1);
      chk($sformatf("%s done c%0d", tag, c), done, exp_done);
      exp_busy = (cnt != 0) && (c >= 1) && (last_pop < 0 || c <= last_pop);
      chk($sformatf("%s busy c%0d", tag, c), busy, exp_busy);
      if (done && done_seen < 0) done_seen = c;
      if (done_seen >= 0 && c == done_seen + 2) break;
    end
    chk({tag, " completed"}, done_seen >= 0, 1'b1);
    chk({tag, " reads"}, reads, cnt);
    chk({tag, " pops"}, pops, cnt);
    if (e_rd >= 0)   chk({tag, " first_read_cycle"}, first_rd, e_rd);
    if (e_val >= 0)  chk({tag, " first_valid_cycle"}, first_val, e_val);
    if (e_done >= 0) chk({tag, " done_cycle"}, done_seen, e_done);
  endtask

  typedef struct {
    int base; int cnt; int mode; int e_rd; int e_val; int e_done;
  } vec_t;
  vec_t vecs [7];

  initial begin
    logic [159:0] t;
    for (int i = 0; i < DEPTH; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      ram[i] = t[OW-1:0];
    end
    ram[20][143:128] = 16'hA5C3;

    vecs[0] = '{4,   4, 0,  1,  3,  7};
    vecs[1] = '{4,   4, 1,  1,  3, -1};
    vecs[2] = '{510, 4, 0,  1,  3,  7};
    vecs[3] = '{0,   0, 0, -1, -1,  1};
    vecs[4] = '{300, 2, 0,  1,  3,  5};
    vecs[5] = '{511, 1, 0,  1,  3,  4};
    vecs[6] = '{100, 7, 2,  1,  3, -1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; obj_ready = 1'b0;
    base_addr = '0; obj_count = '0;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 7; v++)
      run(vecs[v].base, vecs[v].cnt, vecs[v].mode,
          vecs[v].e_rd, vecs[v].e_val, vecs[v].e_done, $sformatf("vec%0d", v));

    for (int r = 0; r < 8; r++)
      run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), 2,
          -1, -1, -1, $sformatf("rand%0d", r));

    // Type/colour unpacking, object held with ready low.
    @(negedge clk) begin start = 1'b1; base_addr = 9'd20; obj_count = 9'd1; obj_ready = 1'b0; end
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("a5c3 valid", obj_valid, 1'b1);
    chk("a5c3 type", obj_type, 4'hA);
    chk("a5c3 color", color, 12'h5C3);
    obj_ready = 1'b1;
    @(negedge clk) obj_ready = 1'b0;
    #1;
    chk("a5c3 done", done, 1'b1);
    chk("a5c3 valid_after", obj_valid, 1'b0);

    // Abort with one object buffered and one in flight.
    @(negedge clk) begin start = 1'b1; base_addr = 9'd8; obj_count = 9'd4; obj_ready = 1'b0; end
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("abort pre_valid", obj_valid, 1'b1);
    chk("abort pre_rd_en", clip_rd_en, 1'b0);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    #1;
    chk("abort valid", obj_valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort quiet_done %0d", k), done, 1'b0);
      chk($sformatf("abort quiet_valid %0d", k), obj_valid, 1'b0);
      chk($sformatf("abort quiet_rd %0d", k), clip_rd_en, 1'b0);
    end
    run(0, 1, 0, 1, 3, 4, "after_abort");

    // Abort wins over start in the same cycle.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; base_addr = 9'd0; obj_count = 9'd3; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("abort_start busy %0d", k), busy, 1'b0);
      chk($sformatf("abort_start rd %0d", k), clip_rd_en, 1'b0);
      chk($sformatf("abort_start done %0d", k), done, 1'b0);
      @(negedge clk);
    end

    // Reset mid-run clears everything without waiting for a clock edge.
    start = 1'b1; base_addr = 9'd4; obj_count = 9'd4; obj_ready = 1'b0;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("midreset pre_valid", obj_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    run(6, 3, 0, 1, 3, 6, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
